pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 35 +++
 rtl/pipe_skid_reg.sv | 111 +++++++++++
 tb/tb_pipe_skid_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for the skid pipeline stage
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; the count parks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register stage; PIPE_SKID_STATS_EN adds the stall counter
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = i_data;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_d  = i_data;
              state_d = TWO;
            end
            2'b01:   state_d = EMPTY;
            2'b11:   main_d  = i_data;
            default: state_d = ONE;
          endcase
        end
        TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake outputs are decoded from the next state so they leave flops directly.
    ready_d = (state_d != TWO);
    valid_d = (state_d != EMPTY);
    full_d  = (state_d == TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_full  = full_q;
  assign o_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_flush),
    .i_inc (valid_q && !i_ready),
    .o_cnt (o_stall_cnt)
  );
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg with a FIFO scoreboard
module tb_pipe_skid_reg;

  localparam int          DW   = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] RV   = 32'h0000_5A5A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_full;
  logic [CW-1:0] o_stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sb_q[$];
  logic          out_fire;
  logic          out_orphan;
  logic [DW-1:0] out_act;
  logic [DW-1:0] out_exp;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W  (DW),
    .RST_VAL (RV),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_full      (o_full),
    .o_stall_cnt (o_stall_cnt)
  );

  // Advance one clock, updating the scoreboard with the transfers that edge performs.
  task automatic tick();
    out_fire   = 1'b0;
    out_orphan = 1'b0;
    if (!i_flush && o_valid && i_ready) begin
      out_fire = 1'b1;
      out_act  = o_data;
      if (sb_q.size() == 0) begin
        out_orphan = 1'b1;
        out_exp    = '0;
      end else begin
        out_exp = sb_q.pop_front();
      end
    end
    if (i_flush) sb_q.delete();
    else if (i_valid && o_ready) sb_q.push_back(i_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
    checks++; if (o_data !== RV) begin failures++; $display("FAIL reset_data got=%h exp=%h", o_data, RV); end
    checks++; if (o_stall_cnt !== '0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", o_stall_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL release_ready_early got=%b exp=0", o_ready); end
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_stream();
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(k);
      tick();
      checks++; if (out_fire && (out_orphan || out_act !== out_exp)) begin failures++; $display("FAIL stream_order got=%h exp=%h", out_act, out_exp); end
      checks++; if (o_valid !== 1'b1 || o_data !== DW'(k)) begin failures++; $display("FAIL stream_latency got=%b/%h exp=1/%h", o_valid, o_data, k); end
      checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL stream_full got=%b exp=0", o_full); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (!out_fire || out_orphan || out_act !== 32'h8) begin failures++; $display("FAIL stream_last got=%h fire=%b exp=8", out_act, out_fire); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", o_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    logic [DW-1:0] want[3];
    logic          c_sent;
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'hA; tick();
    i_data = 32'hB; tick();
    checks++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin failures++; $display("FAIL bp_full got full=%b ready=%b exp 1/0", o_full, o_ready); end
    i_data = 32'hC; tick(); tick();
    checks++; if (o_data !== 32'hA || o_full !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h full=%b exp=a/1", o_data, o_full); end
    i_ready = 1'b1;
    c_sent  = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (i_valid && o_ready) c_sent = 1'b1;
      tick();
      if (c_sent) i_valid = 1'b0;
      if (out_fire) begin
        got.push_back(out_act);
        checks++; if (out_orphan || out_act !== out_exp) begin failures++; $display("FAIL bp_sb got=%h exp=%h", out_act, out_exp); end
      end
    end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (n >= got.size() || got[n] !== want[n]) begin failures++; $display("FAIL bp_order idx=%0d exp=%h", n, want[n]); end
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'h11; tick();
    i_data = 32'h12; tick();
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL flush_setup got=%b exp=1", o_full); end
    i_flush = 1'b1; i_data = 32'hD; tick();
    i_flush = 1'b0; i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_full !== 1'b0) begin failures++; $display("FAIL flush_state got=%b/%b exp=0/0", o_valid, o_full); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
    i_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (out_fire || o_valid !== 1'b0 || o_data === 32'hD) begin failures++; $display("FAIL flush_leak got=%b/%h exp=0/not-d", o_valid, o_data); end
    end
  endtask

  task automatic test_stats();
    logic [CW-1:0] exp5, exp20;
`ifdef PIPE_SKID_STATS_EN
    exp5 = 4'd5; exp20 = 4'd15;
`else
    exp5 = 4'd0; exp20 = 4'd0;
`endif
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'h21; tick();
    i_valid = 1'b0;
    repeat (5) tick();
    checks++; if (o_stall_cnt !== exp5) begin failures++; $display("FAIL stall_5 got=%0d exp=%0d", o_stall_cnt, exp5); end
    repeat (15) tick();
    checks++; if (o_stall_cnt !== exp20) begin failures++; $display("FAIL stall_sat got=%0d exp=%0d", o_stall_cnt, exp20); end
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    checks++; if (o_stall_cnt !== '0) begin failures++; $display("FAIL stall_clr got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'h31; tick();
    i_data = 32'h32; tick();
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%b exp=1", o_full); end
    #3 rst = 1'b1;
    #1;
    sb_q.delete();
    checks++; if (o_valid !== 1'b0 || o_data !== RV) begin failures++; $display("FAIL rmid_async got=%b/%h exp=0/%h", o_valid, o_data, RV); end
    checks++; if (o_full !== 1'b0 || o_ready !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b/%b exp=0/0", o_full, o_ready); end
    i_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rmid_early got=%b exp=0", o_ready); end
    @(posedge clk);
    #1;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL rmid_release got=%b/%b exp=1/0", o_ready, o_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 199) == 0);
      i_data  = $urandom();
      tick();
      if (out_fire) begin
        checks++; if (out_orphan || out_act !== out_exp) begin failures++; $display("FAIL rand_sb cyc=%0d got=%h exp=%h", n, out_act, out_exp); end
      end
      checks++;
      if ((o_ready && o_full) || o_ready !== (sb_q.size() < 2) || o_valid !== (sb_q.size() != 0)) begin
        failures++;
        $display("FAIL rand_state cyc=%0d ready=%b full=%b valid=%b sb=%0d", n, o_ready, o_full, o_valid, sb_q.size());
      end
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (out_fire) begin
        checks++; if (out_orphan || out_act !== out_exp) begin failures++; $display("FAIL rand_drain got=%h exp=%h", out_act, out_exp); end
      end
    end
    checks++; if (sb_q.size() != 0 || o_valid !== 1'b0) begin failures++; $display("FAIL rand_loss left=%0d valid=%b exp=0/0", sb_q.size(), o_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stats();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
